alu_cmd_sequencer: RTL and testbench

Upstream issue stage for the 8-bit combinational ALU. It accepts operation commands over a valid/ready interface and buffers them in a small FIFO. Each command drives the ALU operand/opcode inputs, waits a fixed settle time, captures R, and returns the result over a valid/ready response interface. Unsupported opcodes and divide-by-zero are screened before issue.

---
 rtl/alu_cmd_sequencer_if.sv | 34 +++
 rtl/alu_cmd_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer_if
// Description : Command (valid/ready) and response (valid/ready) bundle for
//               the ALU command sequencer.
//               cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b/cmd_cin : command channel
//               rsp_valid/rsp_ready/rsp_data/rsp_err           : response channel
//               master = command producer / response consumer
//               slave  = the sequencer
// Revision    : 1.0  initial release
// ============================================================================
interface alu_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_cin;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Issue stage for an 8-bit combinational ALU. Commands are
//               buffered in a DEPTH-entry FIFO, screened for unsupported
//               opcodes / divide-by-zero, driven onto registered ALU inputs,
//               held SETTLE cycles, then the ALU result is returned.
// Ports       : clk, rst_n          clock, async active-low reset
//               bus (slave)         command / response handshakes
//               alu_a/b/op/cin      registered ALU operand/opcode outputs
//               alu_r               ALU result input
//               busy                FSM active or FIFO non-empty
// Revision    : 1.0  initial release
// ============================================================================
module alu_cmd_sequencer #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    alu_cmd_sequencer_if.slave    bus,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic [2:0]            alu_op,
    output logic                  alu_cin,
    input  wire logic [7:0]       alu_r,
    output logic                  busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [AW:0]   C_DEPTH  = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] C_SETTLE = CW'(SETTLE);
    localparam logic [CW-1:0] C_ONE    = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
    } cmd_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    cmd_t            fifo_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    state_t          state_q, state_d;

    logic w_full, w_push, w_pop;
    cmd_t w_head;

    assign w_full        = (count_q == C_DEPTH);
    // Ready is gated by rst_n so it drops the instant reset asserts.
    assign bus.cmd_ready = rst_n && !w_full;
    assign w_push        = bus.cmd_valid && bus.cmd_ready;
    assign w_pop         = (state_q == S_IDLE) && (count_q != '0);
    assign w_head        = fifo_q[rd_ptr_q];

    // Storage needs no reset: emptiness is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_q[wr_ptr_q] <= '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b, cin: bus.cmd_cin};
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Screening of the head command
    // ------------------------------------------------------------------
    logic       w_head_ok;
    logic [7:0] w_err_data;

    assign w_head_ok = (w_head.op <= 3'd5) &&
                       !(((w_head.op == 3'd4) || (w_head.op == 3'd5)) && (w_head.b == 8'd0));

    always_comb begin
        w_err_data = 8'h00;
        if (w_head.op == 3'd4)      w_err_data = 8'hFF;
        else if (w_head.op == 3'd5) w_err_data = w_head.a;
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_data_q, rsp_data_d;
    logic [2:0]    alu_op_q, alu_op_d;
    logic          alu_cin_q, alu_cin_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_cin_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_cin_q   <= alu_cin_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_cin_d   = alu_cin_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (w_pop) begin
                    if (w_head_ok) begin
                        alu_a_d   = w_head.a;
                        alu_b_d   = w_head.b;
                        alu_op_d  = w_head.op;
                        alu_cin_d = w_head.cin;
                        cnt_d     = C_SETTLE;
                        state_d   = S_SETTLE;
                    end else begin
                        // Rejected commands never touch the ALU inputs.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = w_err_data;
                        state_d     = S_RESP;
                    end
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == C_ONE) begin
                    rsp_data_d  = alu_r;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign alu_cin      = alu_cin_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy         = (state_q != S_IDLE) || (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Self-checking bench for alu_cmd_sequencer. A reference ALU
//               drives alu_r; a result model and scoreboard check every
//               response, and directed vectors pin timing and literal values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] alu_a, alu_b, alu_r;
    logic [2:0] alu_op;
    logic       alu_cin, busy;

    alu_cmd_sequencer_if bus ();

    alu_cmd_sequencer #(.DEPTH(4), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_r(alu_r), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference combinational ALU
    always_comb begin
        case (alu_op)
            3'd0:    alu_r = alu_a + alu_b + {7'd0, alu_cin};
            3'd1:    alu_r = alu_a - alu_b;
            3'd2:    alu_r = alu_a >> 1;
            3'd3:    alu_r = alu_a << 1;
            3'd4:    alu_r = (alu_b == 8'd0) ? 8'hFF : alu_a / alu_b;
            3'd5:    alu_r = (alu_b == 8'd0) ? alu_a : alu_a % alu_b;
            default: alu_r = 8'h00;
        endcase
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected {err, data} for a command, from the opcode rules directly.
    function automatic logic [8:0] model_rsp(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b, input logic cin);
        logic [8:0] s;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b} + {8'd0, cin}; return {1'b0, s[7:0]}; end
            3'd1: return {1'b0, 8'(a - b)};
            3'd2: return {1'b0, 8'(a >> 1)};
            3'd3: return {1'b0, 8'(a << 1)};
            3'd4: return (b == 8'd0) ? 9'h1FF : {1'b0, 8'(a / b)};
            3'd5: return (b == 8'd0) ? {1'b1, a} : {1'b0, 8'(a % b)};
            default: return 9'h100;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard / compare process (negedge, handshakes take effect at
    // the following posedge)
    // ------------------------------------------------------------------
    logic [8:0] sb [$];
    logic [7:0] rx_q [$];
    int         hs_cyc [$];
    logic       stall = 1'b0;
    logic [8:0] stall_val = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            stall = 1'b0;
        end else begin
            check("busy_vs_model", {31'd0, busy}, {31'd0, sb.size() != 0});
            if (stall) begin
                check("rsp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
                check("rsp_hold_data", {23'd0, bus.rsp_err, bus.rsp_data}, {23'd0, stall_val});
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", {31'd0, bus.rsp_valid}, 32'd0);
                end else begin
                    check("rsp_scoreboard", {23'd0, bus.rsp_err, bus.rsp_data}, {23'd0, sb.pop_front()});
                end
                rx_q.push_back(bus.rsp_data);
                hs_cyc.push_back(cyc);
            end
            if (bus.cmd_valid && bus.cmd_ready)
                sb.push_back(model_rsp(bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_cin));
            stall     = bus.rsp_valid && !bus.rsp_ready;
            stall_val = {bus.rsp_err, bus.rsp_data};
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after posedge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_cin   = cin;
    endtask

    task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin);
        int n = 0;
        set_cmd(op, a, b, cin);
        while (!bus.cmd_ready && n < 200) begin tick(); n++; end
        if (n >= 200) check("push_timeout", 32'd1, 32'd0);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input logic [7:0] data, input logic err);
        int n = 0;
        while (!bus.rsp_valid && n < 50) begin tick(); n++; end
        check({name, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        check({name, "_data"}, {24'd0, bus.rsp_data}, {24'd0, data});
        check({name, "_err"}, {31'd0, bus.rsp_err}, {31'd0, err});
        tick();
    endtask

    task automatic wait_rx(input int cnt);
        int n = 0;
        while (rx_q.size() < cnt && n < 500) begin tick(); n++; end
        check("rx_count", rx_q.size(), cnt);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 500) begin tick(); n++; end
        check("drain_sb_empty", sb.size(), 0);
        check("drain_not_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] sweep_exp [5];
    logic       stale;
    logic       done;

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
        bus.cmd_cin = 1'b0; bus.rsp_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_alu_a", {24'd0, alu_a}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

        // Add with exact latency
        push(3'd0, 8'h12, 8'h34, 1'b1);
        check("add_no_early_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        check("add_alu_a", {24'd0, alu_a}, 32'h12);
        check("add_alu_b", {24'd0, alu_b}, 32'h34);
        check("add_alu_opcin", {28'd0, alu_op, alu_cin}, 32'h1);
        check("add_rsp_not_yet", {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        check("add_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("add_rsp_data", {24'd0, bus.rsp_data}, 32'h47);
        check("add_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        tick();
        push(3'd0, 8'hFF, 8'h01, 1'b0);
        wait_rsp("add_wrap", 8'h00, 1'b0);

        // Op sweep, back-to-back
        rx_q.delete(); hs_cyc.delete();
        sweep_exp[0] = 8'h30; sweep_exp[1] = 8'h40; sweep_exp[2] = 8'h02;
        sweep_exp[3] = 8'h0E; sweep_exp[4] = 8'h02;
        push(3'd1, 8'h50, 8'h20, 1'b0);
        push(3'd2, 8'h81, 8'h00, 1'b0);
        push(3'd3, 8'h81, 8'h00, 1'b0);
        push(3'd4, 8'd100, 8'd7, 1'b0);
        push(3'd5, 8'd100, 8'd7, 1'b0);
        wait_rx(5);
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) check($sformatf("sweep_data%0d", i), {24'd0, rx_q[i]}, {24'd0, sweep_exp[i]});
            if (i > 0 && i < hs_cyc.size()) check($sformatf("sweep_gap%0d", i), hs_cyc[i] - hs_cyc[i-1], 3);
        end
        drain();

        // Fill / backpressure
        rx_q.delete();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_cmd(3'd0, 8'(8'h10 + i), 8'h01, 1'b0);
            check($sformatf("fill_ready%0d", i), {31'd0, bus.cmd_ready}, 32'd1);
            tick();
        end
        set_cmd(3'd0, 8'h15, 8'h01, 1'b0);
        check("fill_full", {31'd0, bus.cmd_ready}, 32'd0);
        repeat (3) tick();
        check("stall_full", {31'd0, bus.cmd_ready}, 32'd0);
        check("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("stall_data", {24'd0, bus.rsp_data}, 32'h11);
        bus.rsp_ready = 1'b1;
        tick();
        check("ready_not_yet", {31'd0, bus.cmd_ready}, 32'd0);
        tick();
        check("ready_rise", {31'd0, bus.cmd_ready}, 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        wait_rx(6);
        for (int i = 0; i < 6; i++)
            if (i < rx_q.size()) check($sformatf("drain_order%0d", i), {24'd0, rx_q[i]}, 32'h11 + i);
        drain();

        // Error screening
        push(3'd7, 8'h33, 8'h44, 1'b1);
        check("err7_no_early", {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        check("err7_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("err7_err_data", {23'd0, bus.rsp_err, bus.rsp_data}, 32'h100);
        check("err7_alu_hold", {13'd0, alu_a, alu_b, alu_op}, {13'd0, 8'h15, 8'h01, 3'd0});
        tick();
        push(3'd4, 8'h10, 8'h00, 1'b0);
        wait_rsp("div0", 8'hFF, 1'b1);
        push(3'd5, 8'h2A, 8'h00, 1'b0);
        wait_rsp("mod0", 8'h2A, 1'b1);
        drain();

        // Reset mid-operation
        set_cmd(3'd0, 8'h21, 8'h01, 1'b0);
        tick();
        set_cmd(3'd0, 8'h30, 8'h02, 1'b0);
        tick();
        set_cmd(3'd1, 8'h40, 8'h03, 1'b0);
        check("rst_mid_alu_loaded", {24'd0, alu_a}, 32'h21);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_alu", {13'd0, alu_a, alu_b, alu_op}, 32'd0);
        check("rst_mid_rsp", {22'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 32'd0);
        check("rst_mid_ready_busy", {30'd0, bus.cmd_ready, busy}, 32'd0);
        bus.cmd_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        stale = 1'b0;
        repeat (6) begin tick(); if (bus.rsp_valid) stale = 1'b1; end
        check("no_stale_rsp", {31'd0, stale}, 32'd0);
        push(3'd0, 8'h01, 8'h01, 1'b0);
        wait_rsp("post_rst_add", 8'h02, 1'b0);

        // Pointer wrap with pushes paced to coincide with pops
        rx_q.delete();
        for (int i = 0; i < 16; i++) begin
            push(3'($urandom_range(0, 5)), 8'($urandom), 8'($urandom) | 8'h01, 1'($urandom));
            if (i >= 3) repeat (2) tick();
        end
        drain();
        check("wrap_count", rx_q.size(), 16);

        // Mixed ops, random gaps and response backpressure
        rx_q.delete();
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    push(3'($urandom_range(0, 7)), 8'($urandom),
                         ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), 1'($urandom));
                    repeat ($urandom_range(0, 3)) tick();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tick();
                    bus.rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.rsp_ready = 1'b1;
        drain();
        check("random_count", rx_q.size(), 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
